alu_flag_writeback: RTL and testbench

- Stage directly downstream of the ALU.
- Accepts ALU results and the 8-bit PSR vector {3'b0,Z,C,F,N,L} under a valid/ready handshake.
- Holds the architectural PSR register and evaluates branch conditions against it.
- Buffers register-file writes in a small FIFO so a stalled register-file write port back-pressures the ALU, not the whole pipe.

---
 rtl/alu_flag_writeback.sv | 133 +++++++++++++
 tb/tb_alu_flag_writeback.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_flag_writeback.sv
// alu_flag_writeback: PSR register, branch verdicts and writeback FIFO after the ALU.
// Optional macro ALU_WB_BYPASS_EN: same-cycle register-file write when the FIFO is empty.
module alu_flag_writeback #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [7:0]       in_psr,
  input  logic [AW-1:0]    in_dst,
  input  logic             in_wb_en,
  input  logic             in_flag_we,
  input  logic             in_cond_en,
  input  logic [3:0]       in_cond,
  output logic             rf_we,
  output logic [AW-1:0]    rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  input  logic             rf_ready,
  output logic [7:0]       psr_q,
  output logic             branch_valid,
  output logic             branch_taken
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [AW-1:0]    dmem [DEPTH];
  logic [WIDTH-1:0] wmem [DEPTH];
  logic [PW-1:0]    rp;
  logic [PW-1:0]    wp;
  logic [CW-1:0]    cnt;
  logic             full;
  logic             empty;
  logic             acc;
  logic             push;
  logic             pop;
  logic             byp;
  logic             cond_hit;
  logic             unused_psr;

  assign unused_psr = ^in_psr[7:5];

  assign full     = (cnt == FULLC);
  assign empty    = (cnt == '0);
  assign in_ready = ~full;
  assign acc      = in_valid & in_ready;

`ifdef ALU_WB_BYPASS_EN
  assign byp   = empty & rf_ready & in_valid & in_wb_en;
  assign rf_we = ~empty | (in_valid & in_wb_en);
  assign rf_waddr = ~empty ? dmem[rp] :
                    (in_valid & in_wb_en) ? in_dst : '0;
  assign rf_wdata = ~empty ? wmem[rp] :
                    (in_valid & in_wb_en) ? in_result : '0;
`else
  assign byp      = 1'b0;
  assign rf_we    = ~empty;
  assign rf_waddr = empty ? '0 : dmem[rp];
  assign rf_wdata = empty ? '0 : wmem[rp];
`endif

  assign push = acc & in_wb_en & ~byp;
  assign pop  = rf_we & rf_ready & ~empty;

  // branch condition decode against the pre-update PSR
  always_comb begin
    cond_hit = 1'b0;
    unique case (in_cond)
      4'b0000: cond_hit = psr_q[4];
      4'b0001: cond_hit = ~psr_q[4];
      4'b0010: cond_hit = psr_q[3];
      4'b0011: cond_hit = ~psr_q[3];
      4'b0100: cond_hit = psr_q[0];
      4'b0101: cond_hit = ~psr_q[0];
      4'b0110: cond_hit = psr_q[1];
      4'b0111: cond_hit = ~psr_q[1];
      4'b1000: cond_hit = psr_q[2];
      4'b1001: cond_hit = ~psr_q[2];
      4'b1010: cond_hit = ~psr_q[0] & ~psr_q[4];
      4'b1011: cond_hit = psr_q[0] | psr_q[4];
      4'b1100: cond_hit = ~psr_q[1] & ~psr_q[4];
      4'b1101: cond_hit = psr_q[1] | psr_q[4];
      4'b1110: cond_hit = 1'b1;
      4'b1111: cond_hit = 1'b0;
      default: cond_hit = 1'b0;
    endcase
  end

  // FIFO storage; contents are don't-care until count covers them
  always_ff @(posedge clk) begin
    if (push) begin
      dmem[wp] <= in_dst;
      wmem[wp] <= in_result;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + ONE;
        2'b01:   cnt <= cnt - ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // PSR register and one-cycle branch verdict
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psr_q        <= 8'h00;
      branch_valid <= 1'b0;
      branch_taken <= 1'b0;
    end else begin
      if (acc & in_flag_we) psr_q <= {3'b000, in_psr[4:0]};
      branch_valid <= acc & in_cond_en;
      branch_taken <= acc & in_cond_en & cond_hit;
    end
  end

endmodule

// File: tb/tb_alu_flag_writeback.sv
// tb_alu_flag_writeback: directed checks of FIFO, PSR, branch verdicts and reset.
// Default build only (ALU_WB_BYPASS_EN undefined).
module tb_alu_flag_writeback;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic [7:0]  in_psr;
  logic [3:0]  in_dst;
  logic        in_wb_en;
  logic        in_flag_we;
  logic        in_cond_en;
  logic [3:0]  in_cond;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        rf_ready;
  logic [7:0]  psr_q;
  logic        branch_valid;
  logic        branch_taken;

  int checks = 0;
  int errors = 0;
  int pulses;

  alu_flag_writeback #(.WIDTH(16), .DEPTH(2), .AW(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_psr(in_psr),
    .in_dst(in_dst), .in_wb_en(in_wb_en),
    .in_flag_we(in_flag_we), .in_cond_en(in_cond_en),
    .in_cond(in_cond),
    .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_ready(rf_ready),
    .psr_q(psr_q), .branch_valid(branch_valid),
    .branch_taken(branch_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    in_wb_en   = 1'b0;
    in_flag_we = 1'b0;
    in_cond_en = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_result = '0;
    in_psr    = '0;
    in_dst    = '0;
    in_cond   = '0;
    rf_ready  = 1'b1;
    idle();
    #12;
    chk("rst_psr", 32'(psr_q), 32'h00);
    chk("rst_rfwe", 32'(rf_we), 32'h0);
    chk("rst_bv", 32'(branch_valid), 32'h0);
    chk("rst_waddr", 32'(rf_waddr), 32'h0);
    chk("rst_wdata", 32'(rf_wdata), 32'h0);
    reset_n = 1'b1;
    #1;
    chk("rst_ready", 32'(in_ready), 32'h1);

    // single write, 1-cycle latency
    step();
    in_valid = 1'b1; in_wb_en = 1'b1;
    in_result = 16'h1234; in_dst = 4'd3;
    step();
    idle();
    chk("t1_we", 32'(rf_we), 32'h1);
    chk("t1_addr", 32'(rf_waddr), 32'h3);
    chk("t1_data", 32'(rf_wdata), 32'h1234);
    step();
    chk("t1_we_off", 32'(rf_we), 32'h0);

    // back-pressure with stalled write port
    rf_ready = 1'b0;
    in_valid = 1'b1; in_wb_en = 1'b1;
    in_result = 16'h0001; in_dst = 4'd1;
    step();
    in_result = 16'h0002; in_dst = 4'd2;
    step();
    chk("t2_full", 32'(in_ready), 32'h0);
    in_result = 16'h0003; in_dst = 4'd5;
    step();
    chk("t2_still_full", 32'(in_ready), 32'h0);
    chk("t2_hold_addr", 32'(rf_waddr), 32'h1);
    chk("t2_hold_data", 32'(rf_wdata), 32'h0001);
    idle();
    rf_ready = 1'b1;
    #1;
    chk("t2_pop1_we", 32'(rf_we), 32'h1);
    step();
    chk("t2_ready_back", 32'(in_ready), 32'h1);
    chk("t2_pop2_addr", 32'(rf_waddr), 32'h2);
    chk("t2_pop2_data", 32'(rf_wdata), 32'h0002);
    step();
    chk("t2_drained", 32'(rf_we), 32'h0);

    // PSR masking and branch verdicts
    in_valid = 1'b1; in_flag_we = 1'b1; in_psr = 8'hF0;
    step();
    chk("t3_psr", 32'(psr_q), 32'h10);
    in_flag_we = 1'b0; in_cond_en = 1'b1; in_cond = 4'b0000;
    step();
    chk("t3_eq_v", 32'(branch_valid), 32'h1);
    chk("t3_eq_t", 32'(branch_taken), 32'h1);
    in_cond = 4'b0001;
    step();
    chk("t3_ne_v", 32'(branch_valid), 32'h1);
    chk("t3_ne_t", 32'(branch_taken), 32'h0);
    idle();
    step();
    chk("t3_pulse_end", 32'(branch_valid), 32'h0);
    chk("t3_taken_clr", 32'(branch_taken), 32'h0);

    // pre-update flags for a combined item
    in_valid = 1'b1; in_flag_we = 1'b1; in_psr = 8'h00;
    step();
    in_psr = 8'h10; in_cond_en = 1'b1; in_cond = 4'b0000;
    step();
    idle();
    chk("t4_v", 32'(branch_valid), 32'h1);
    chk("t4_t", 32'(branch_taken), 32'h0);
    chk("t4_psr", 32'(psr_q), 32'h10);

    // L flag conditions
    in_valid = 1'b1; in_flag_we = 1'b1; in_psr = 8'h01;
    step();
    in_flag_we = 1'b0; in_cond_en = 1'b1;
    in_cond = 4'b1011;
    step();
    chk("t5_hs", 32'(branch_taken), 32'h1);
    in_cond = 4'b1010;
    step();
    chk("t5_lo", 32'(branch_taken), 32'h0);
    in_cond = 4'b1110;
    step();
    chk("t5_uc", 32'(branch_taken), 32'h1);
    in_cond = 4'b1111;
    step();
    chk("t5_nv", 32'(branch_taken), 32'h0);
    in_cond = 4'b0100;
    step();
    chk("t5_hi", 32'(branch_taken), 32'h1);
    in_cond = 4'b1100;
    step();
    chk("t5_lt", 32'(branch_taken), 32'h1);
    idle();

    // async reset with buffered writes and a pending verdict
    rf_ready = 1'b0;
    in_valid = 1'b1; in_wb_en = 1'b1;
    in_result = 16'hAAAA; in_dst = 4'd7;
    step();
    in_result = 16'hBBBB; in_dst = 4'd8;
    in_cond_en = 1'b1; in_cond = 4'b1110;
    step();
    idle();
    chk("t6_pre_we", 32'(rf_we), 32'h1);
    chk("t6_pre_bv", 32'(branch_valid), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_we", 32'(rf_we), 32'h0);
    chk("t6_bv", 32'(branch_valid), 32'h0);
    chk("t6_bt", 32'(branch_taken), 32'h0);
    chk("t6_psr", 32'(psr_q), 32'h00);
    chk("t6_addr", 32'(rf_waddr), 32'h0);
    chk("t6_data", 32'(rf_wdata), 32'h0);
    #1;
    reset_n = 1'b1;
    rf_ready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rf_we) pulses++;
    end
    chk("t6_no_old", 32'(pulses), 32'h0);
    chk("t6_ready", 32'(in_ready), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
